// File: rtl/hazard_pipe_pkg.sv
// Shared constants and helpers for the hazard/forwarding unit.
// Stage entries carry a destination register and its remaining Tnew.
package hazard_pipe_pkg;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_E     = 2'd1;
   localparam logic [1:0] FWD_M     = 2'd2;
   localparam logic [1:0] FWD_W     = 2'd3;
   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic [1:0] TNEW_LOAD = 2'd2;
   localparam logic [1:0] TNEW_ALU  = 2'd1;

   function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
      return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
   endfunction

   // A source stalls if a younger producer will not have its result by the time it is used.
   function automatic logic src_hz(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                   input logic [4:0] m_a3, input logic [1:0] m_tnew);
      return (src != 5'd0) &&
             (((e_a3 == src) && (e_tnew > tuse)) || ((m_a3 == src) && (m_tnew > tuse)));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                          input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                          input logic [4:0] w_a3);
      if (src == 5'd0)                            return FWD_RF;
      else if ((e_a3 == src) && (e_tnew == 2'd0)) return FWD_E;
      else if ((m_a3 == src) && (m_tnew == 2'd0)) return FWD_M;
      else if (w_a3 == src)                       return FWD_W;
      else                                        return FWD_RF;
   endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One tracked pipeline stage entry: destination register plus remaining Tnew.
// Bubble and flush both load an empty entry; reset overrides everything.
module hz_stage_reg
   import hazard_pipe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_bubble,
   input  logic       i_dec,
   input  logic       i_flush,
   input  logic [4:0] i_a3,
   input  logic [1:0] i_tnew,
   output logic [4:0] o_a3,
   output logic [1:0] o_tnew
);

   logic [4:0] r_a3;
   logic [1:0] r_tnew;

   always_ff @(posedge clk) begin
      if (reset || i_flush || i_bubble) begin
         r_a3   <= 5'd0;
         r_tnew <= 2'd0;
      end else begin
         r_a3   <= i_a3;
         r_tnew <= i_dec ? tnew_dec(i_tnew) : i_tnew;
      end
   end

   assign o_a3   = r_a3;
   assign o_tnew = r_tnew;

endmodule

// File: rtl/hazard_pipe.sv
// Tnew/Tuse hazard unit: tracks E/M/W destinations, raises stall, selects forwards
// and counts stall cycles with saturation.
module hazard_pipe
   import hazard_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_a3,
   input  logic [1:0]  d_tnew,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic        d_is_md,
   input  logic        md_busy,
   input  logic        flush,
   output logic        stall,
   output logic [1:0]  fwd_rs,
   output logic [1:0]  fwd_rt,
   output logic [4:0]  e_a3,
   output logic [4:0]  m_a3,
   output logic [4:0]  w_a3,
   output logic [1:0]  e_tnew,
   output logic [1:0]  m_tnew,
   output logic [31:0] stall_cnt
);

   logic        w_rs_hz;
   logic        w_rt_hz;
   logic        w_md_hz;
   logic [4:0]  r_w_a3;
   logic [31:0] r_stall_cnt;

   always_comb begin
      w_rs_hz = src_hz(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
      w_rt_hz = src_hz(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
      w_md_hz = d_is_md && md_busy;
      stall   = w_rs_hz || w_rt_hz || w_md_hz;
      fwd_rs  = fwd_sel(d_rs, e_a3, e_tnew, m_a3, m_tnew, r_w_a3);
      fwd_rt  = fwd_sel(d_rt, e_a3, e_tnew, m_a3, m_tnew, r_w_a3);
   end

   hz_stage_reg u_e_stage (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (stall),
      .i_dec    (1'b0),
      .i_flush  (flush),
      .i_a3     (d_a3),
      .i_tnew   (d_tnew),
      .o_a3     (e_a3),
      .o_tnew   (e_tnew)
   );

   hz_stage_reg u_m_stage (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (1'b0),
      .i_dec    (1'b1),
      .i_flush  (flush),
      .i_a3     (e_a3),
      .i_tnew   (e_tnew),
      .o_a3     (m_a3),
      .o_tnew   (m_tnew)
   );

   always_ff @(posedge clk) begin
      if (reset || flush) r_w_a3 <= 5'd0;
      else                r_w_a3 <= m_a3;
   end

   always_ff @(posedge clk) begin
      if (reset)                                       r_stall_cnt <= 32'd0;
      else if (stall && !flush && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign w_a3      = r_w_a3;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_pipe.sv
// Directed bench for hazard_pipe: a stage-list model checked every cycle,
// plus literal expectations for the key hazard, forwarding, flush and reset cases.
module tb_hazard_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_a3, d_rs, d_rt;
   logic [1:0]  d_tnew, d_tuse_rs, d_tuse_rt;
   logic        d_is_md, md_busy, flush;
   logic        stall;
   logic [1:0]  fwd_rs, fwd_rt;
   logic [4:0]  e_a3, m_a3, w_a3;
   logic [1:0]  e_tnew, m_tnew;
   logic [31:0] stall_cnt;

   int vectors = 0;
   int miscompares = 0;
   logic chk_en = 1'b0;
   logic preload = 1'b0;

   // Model: stage list, index 0 = E, 1 = M, 2 = W; tnew as plain integers.
   logic [4:0]  ma3 [3];
   int unsigned mtn [3];
   longint      mcnt;

   hazard_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .d_a3      (d_a3),
      .d_tnew    (d_tnew),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_tuse_rs (d_tuse_rs),
      .d_tuse_rt (d_tuse_rt),
      .d_is_md   (d_is_md),
      .md_busy   (md_busy),
      .flush     (flush),
      .stall     (stall),
      .fwd_rs    (fwd_rs),
      .fwd_rt    (fwd_rt),
      .e_a3      (e_a3),
      .m_a3      (m_a3),
      .w_a3      (w_a3),
      .e_tnew    (e_tnew),
      .m_tnew    (m_tnew),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic model_stall();
      logic s;
      s = d_is_md && md_busy;
      for (int i = 0; i < 2; i++) begin
         if (d_rs != 0 && ma3[i] == d_rs && mtn[i] > int'(d_tuse_rs)) s = 1'b1;
         if (d_rt != 0 && ma3[i] == d_rt && mtn[i] > int'(d_tuse_rt)) s = 1'b1;
      end
      return s;
   endfunction

   // Youngest stage whose result is ready wins; register 0 always reads the regfile.
   function automatic int model_fwd(input logic [4:0] src);
      if (src == 0) return 0;
      for (int i = 0; i < 3; i++)
         if (ma3[i] == src && mtn[i] == 0) return i + 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      logic st;
      longint base;
      st   = model_stall();
      base = preload ? 64'hFFFF_FFFE : mcnt;
      if (reset || flush) begin
         for (int i = 0; i < 3; i++) begin
            ma3[i] <= 5'd0;
            mtn[i] <= 0;
         end
         mcnt <= reset ? 0 : base;
      end else begin
         ma3[2] <= ma3[1];
         mtn[2] <= 0;
         ma3[1] <= ma3[0];
         mtn[1] <= (mtn[0] == 0) ? 0 : mtn[0] - 1;
         ma3[0] <= st ? 5'd0 : d_a3;
         mtn[0] <= st ? 0 : int'(d_tnew);
         mcnt   <= (st && base < 64'hFFFF_FFFF) ? base + 1 : base;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", 32'(stall), 32'(model_stall()));
         chk("fwd_rs", 32'(fwd_rs), 32'(model_fwd(d_rs)));
         chk("fwd_rt", 32'(fwd_rt), 32'(model_fwd(d_rt)));
         chk("e_a3", 32'(e_a3), 32'(ma3[0]));
         chk("m_a3", 32'(m_a3), 32'(ma3[1]));
         chk("w_a3", 32'(w_a3), 32'(ma3[2]));
         chk("e_tnew", 32'(e_tnew), mtn[0]);
         chk("m_tnew", 32'(m_tnew), mtn[1]);
         if (!preload) chk("stall_cnt", stall_cnt, mcnt[31:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_a3 = 0; d_tnew = 0; d_rs = 0; d_rt = 0;
      d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
      d_is_md = 0; md_busy = 0; flush = 0;
   endtask

   task automatic issue(input logic [4:0] a3, input logic [1:0] tn);
      idle();
      d_a3 = a3; d_tnew = tn;
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      reset = 1'b0;
      #2 chk("rst e_a3", 32'(e_a3), 0);
      chk("rst stall_cnt", stall_cnt, 0);
      chk("rst stall", 32'(stall), 0);

      // Load-use: two bubbles, then the load value comes from W.
      issue(8, 2);
      d_rs = 8; d_tuse_rs = 0;
      #2 chk("lu stall1", 32'(stall), 1);
      tick();
      #2 chk("lu stall2", 32'(stall), 1);
      chk("lu m_tnew", 32'(m_tnew), 1);
      tick();
      #2 chk("lu stall3", 32'(stall), 0);
      chk("lu fwd_rs", 32'(fwd_rs), 3);
      chk("lu cnt", stall_cnt, 2);
      tick();

      // ALU result feeding a branch.
      issue(9, 1);
      d_rs = 9; d_tuse_rs = 0;
      #2 chk("alu stall", 32'(stall), 1);
      tick();
      #2 chk("alu stall off", 32'(stall), 0);
      chk("alu m_a3", 32'(m_a3), 9);
      chk("alu m_tnew", 32'(m_tnew), 0);
      chk("alu fwd_rs", 32'(fwd_rs), 2);
      tick();

      // Same register in E, M and W: E wins; register 0 never forwards.
      issue(5, 0);
      issue(5, 0);
      issue(5, 0);
      d_rs = 5; d_rt = 5; d_tuse_rs = 0; d_tuse_rt = 1;
      #2 chk("pri fwd_rs", 32'(fwd_rs), 1);
      chk("pri fwd_rt", 32'(fwd_rt), 1);
      d_rs = 0;
      #1 chk("pri r0 fwd", 32'(fwd_rs), 0);
      chk("pri r0 stall", 32'(stall), 0);
      tick();

      // rt hazard against a load, and Tuse 3 never stalls.
      issue(4, 2);
      d_rt = 4; d_tuse_rt = 3;
      #2 chk("tuse3 stall", 32'(stall), 0);
      d_tuse_rt = 1;
      #1 chk("rt stall", 32'(stall), 1);
      tick();
      idle();
      tick();

      // Flush wins over a pending stall and does not count it.
      issue(8, 2);
      d_rs = 8; d_tuse_rs = 0; flush = 1;
      #2 chk("fl stall", 32'(stall), 1);
      tick();
      idle();
      #2 chk("fl e_a3", 32'(e_a3), 0);
      chk("fl m_a3", 32'(m_a3), 0);
      chk("fl w_a3", 32'(w_a3), 0);
      chk("fl stall", 32'(stall), 0);
      chk("fl cnt", stall_cnt, 4);

      // Mult/div busy: five stalled cycles, each leaving a bubble in E.
      for (int i = 0; i < 5; i++) begin
         d_a3 = 7; d_tnew = 1; d_is_md = 1; md_busy = 1;
         #2 chk("md stall", 32'(stall), 1);
         tick();
         #2 chk("md bubble", 32'(e_a3), 0);
      end
      md_busy = 0;
      #1 chk("md release", 32'(stall), 0);
      tick();
      #2 chk("md e_a3", 32'(e_a3), 7);
      chk("md cnt", stall_cnt, 9);

      // Reset in the middle of a hazard.
      issue(8, 2);
      idle();
      tick();
      #2 chk("rh m_a3", 32'(m_a3), 8);
      chk("rh m_tnew", 32'(m_tnew), 1);
      d_rs = 8; d_tuse_rs = 0; reset = 1;
      #1 chk("rh stall", 32'(stall), 1);
      tick();
      reset = 0;
      #2 chk("rh m_a3 clr", 32'(m_a3), 0);
      chk("rh stall clr", 32'(stall), 0);
      chk("rh cnt clr", stall_cnt, 0);

      // Counter saturation from a preloaded value.
      idle();
      d_is_md = 1; md_busy = 1;
      preload = 1;
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      #1 release dut.r_stall_cnt;
      tick();
      preload = 0;
      #2 chk("sat cnt1", stall_cnt, 32'hFFFF_FFFF);
      tick();
      #2 chk("sat cnt2", stall_cnt, 32'hFFFF_FFFF);
      idle();
      reset = 1;
      tick();
      reset = 0;
      #2 chk("sat rst", stall_cnt, 0);
      tick();
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
